// File: rtl/pri_encode_scan_pkg.sv
// pri_encode_scan_pkg
// Shared constants for the priority encoder / seven-segment scanner.
//   HEX_SEG   : 16-entry active-low segment table, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK : all segments off (active-low, so all ones)
package pri_encode_scan_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/pri_encode_scan_hex7seg.sv
// hex7seg
// Purely combinational hex-digit to seven-segment decoder.
//   nib : 4-bit value to show
//   seg : active-low segment pattern {g,f,e,d,c,b,a}
module hex7seg
    import pri_encode_scan_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Straight table lookup; the table lives in the package so every
    // display block in the design shares one glyph set.
    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/pri_encode_scan.sv
// pri_encode_scan
// Registered priority encoder with a time-multiplexed, common-anode
// seven-segment readout of {idc, y} in hex.
//   clk   : system clock, all state on the rising edge
//   rst_n : synchronous active-low reset
//   x     : request vector, bit W-1 has the highest priority
//   en    : encoder enable; when low the result is cleared
//   hold  : keep the last valid result while x is all zeros
//   idc   : registered valid flag, 1 when y is a real index
//   y     : registered index of the highest set bit of x
//   seg   : active-low segment pattern {g,f,e,d,c,b,a}
//   an    : active-low digit enables, one digit lit at a time
module pri_encode_scan
    import pri_encode_scan_pkg::*;
#(
    parameter int W    = 16,
    parameter int IW   = $clog2(W),
    parameter int NDIG = 2,
    parameter int SCAN = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [W-1:0]    x,
    input  logic            en,
    input  logic            hold,
    output logic            idc,
    output logic [IW-1:0]   y,
    output logic [6:0]      seg,
    output logic [NDIG-1:0] an
);

    localparam int SCW = (SCAN > 1) ? $clog2(SCAN) : 1;
    localparam int DGW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int DW  = NDIG * 4;

    logic [IW-1:0]  hit_idx;
    logic           hit;
    logic [SCW-1:0] sc;
    logic [DGW-1:0] dig;
    logic [DW-1:0]  dval;
    logic [3:0]     nib;
    logic [6:0]     seg_next;

    // Priority search runs low to high so the highest set bit is the
    // last one written and therefore wins.
    always_comb begin
        hit_idx = '0;
        hit     = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (x[i]) begin
                hit_idx = IW'(i);
                hit     = 1'b1;
            end
        end
    end

    // Encoder result register. Disabled clears unconditionally; hold only
    // matters when enabled and no request is present.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y   <= '0;
            idc <= 1'b0;
        end else if (!en) begin
            y   <= '0;
            idc <= 1'b0;
        end else if (hit) begin
            y   <= hit_idx;
            idc <= 1'b1;
        end else if (!hold) begin
            y   <= '0;
            idc <= 1'b0;
        end
    end

    // The displayed value is the valid flag stacked on top of the index,
    // zero-extended to fill all digits.
    assign dval = DW'({idc, y});

    // Pick the nibble for the digit currently being scanned.
    always_comb begin
        nib = 4'h0;
        for (int k = 0; k < NDIG; k++) begin
            if (dig == DGW'(k)) begin
                nib = dval[4*k +: 4];
            end
        end
    end

    hex7seg u_hex7seg (
        .nib (nib),
        .seg (seg_next)
    );

    // Dwell counter and digit index. The digit only advances when the
    // dwell counter wraps, so each digit gets SCAN cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sc  <= '0;
            dig <= '0;
        end else if (sc == SCW'(SCAN - 1)) begin
            sc <= '0;
            if (dig == DGW'(NDIG - 1)) begin
                dig <= '0;
            end else begin
                dig <= dig + 1'b1;
            end
        end else begin
            sc <= sc + 1'b1;
        end
    end

    // Display pins are registered from the current digit index, so the
    // pins lag dig by one cycle and digit 0 lights on the first cycle
    // after reset release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg <= SEG_BLANK;
            an  <= '1;
        end else begin
            seg <= seg_next;
            an  <= ~(NDIG'(1) << dig);
        end
    end

endmodule

// File: doc/pri_encode_scan.md
# pri_encode_scan

Parametrised, registered priority encoder with a time-multiplexed seven-segment readout. Samples a W-bit request vector each cycle and registers the index of the highest set bit plus a valid flag, with an optional hold mode that keeps the last valid result. Drives an NDIG-digit common-anode display, active-low, by scanning one digit at a time. Sits at the board top level between the switch inputs and the display pins.

## Interface
- W, 16: request vector width; W >= 2.
- IW, $clog2(W): index width; derived, not overridden.
- NDIG, 2: display digits; NDIG*4 >= IW+1.
- SCAN, 1000: clock cycles each digit stays lit; SCAN >= 1.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- x  in  W  request vector; bit W-1 has highest priority.
- en  in  1  encoder enable.
- hold  in  1  1 = keep last valid result while x == 0.
- idc  out  1  registered valid flag; 1 when y holds a real index.
- y  out  IW  registered index of the highest set bit of x.
- seg  out  7  segment pattern {g,f,e,d,c,b,a}; active-low.
- an  out  NDIG  digit enables; active-low, one-hot-low while scanning.

## Operation
- Encoder register, evaluated every cycle:
  - en=0: y<=0, idc<=0. hold is ignored.
  - en=1 and x!=0: y<=index of the highest set bit, idc<=1.
  - en=1, x==0, hold=0: y<=0, idc<=0.
  - en=1, x==0, hold=1: y and idc keep their values.
- Display value D = zero-extend({idc, y}) to NDIG*4 bits. Digit k shows nibble D[4k+3:4k] as hex.
- Hex patterns, active-low: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
- Scan counter sc counts 0..SCAN-1. When sc==SCAN-1, sc wraps to 0 and the digit index dig advances 0..NDIG-1, wrapping to 0.
- seg and an are registered from dig and the current y/idc:
  - an <= ~(1<<dig)
  - seg <= hex(nibble[dig])
- Deasserting hold while x==0 and en=1 clears y and idc on the next edge.

## Timing
- Reset values on the clk edge with rst_n=0: y=0, idc=0, sc=0, dig=0, seg=7'h7F (blank), an=all ones (all digits off).
- Reset applied mid-scan or mid-hold takes effect on the next edge; nothing survives it.
- Latency x/en/hold -> y/idc: 1 cycle.
- Latency y/idc -> seg: 1 cycle, giving 2 cycles total from x to the visible pattern while that digit is lit.
- First cycle after reset release: an=~1 and seg=hex(D[3:0]), i.e. digit 0 lights.
- Each digit is lit for exactly SCAN consecutive cycles. Full refresh period = NDIG*SCAN.
- With SCAN=1, dig advances every cycle.
- With NDIG=1, an stays 0 and dig never changes.
- No handshake; inputs may change every cycle and the encoder register follows them.

## Structure
- Package pri_encode_scan_pkg holds:
  - the 16-entry active-low hex segment table, as a localparam array or function;
  - SEG_BLANK = 7'h7F.
- Sub-module hex7seg: 4-bit nibble in, 7-bit active-low pattern out; purely combinational; one instance fed by the selected nibble.
- Encoder: for-loop priority search, low index to high so the last hit wins.
- Scan counter width $clog2(SCAN) (minimum 1). Digit counter width $clog2(NDIG) (minimum 1).

## Test plan
All scenarios use W=16, NDIG=2, SCAN=4.
- Reset: hold rst_n=0 for 3 cycles with x=FFFF, en=1 -> y=0, idc=0, seg=7F, an=2'b11. Release -> next cycle an=2'b10.
- Priority: en=1, apply x=0001, 0300, 8001 in consecutive cycles -> y = 0, 9, 15 (idc=1 each) one cycle later. For x=8001: D=0x1F, digit 0 seg=0E ('F'), digit 1 seg=79 ('1').
- Hold: x=0040 (y=6, idc=1), then x=0 with hold=1 for 10 cycles -> y=6, idc=1 unchanged. Drop hold -> next cycle y=0, idc=0, digit 0 seg=40.
- Enable: x=1000 with en=0 -> y=0, idc=0. Raise en -> next cycle y=12, idc=1, D=0x1C, digit 0 seg=46 ('C').
- Scan cadence: after reset release, sample an for 16 cycles -> pattern 10,10,10,10,01,01,01,01 repeating, with seg matching the selected nibble each cycle.
- Mid-scan reset: assert rst_n=0 when sc=2, dig=1, hold-latched y=6 -> all outputs return to reset values next edge. On release, scan restarts at digit 0 with the full 4-cycle dwell.
